// File: rtl/alu_sequencer_pkg.sv
// Shared ALU definitions: operation encodings and the sequencer FSM state type.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OPERAND   = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_RESPOND   = 3'd4
  } alu_seq_state_e;

  // Encoding presented on the ALU bus whenever no operation is executing.
  localparam alu_op_e ALU_OP_IDLE = ALU_ADD;

endpackage

// File: rtl/alu.sv
// Combinational ALU; carry is the carry-out for ADD and the borrow for SUB.
module alu
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 8
) (
  input  alu_op_e                   alu_op,
  input  logic [DATA_BUS_WIDTH-1:0] alu_register1,
  input  logic [DATA_BUS_WIDTH-1:0] alu_register2,
  output logic [DATA_BUS_WIDTH-1:0] alu_result,
  output logic                      alu_is_carry,
  output logic                      alu_is_zero
);

  logic [DATA_BUS_WIDTH:0] wide;

  always_comb begin
    wide = '0;
    case (alu_op)
      ALU_ADD: wide = {1'b0, alu_register1} + {1'b0, alu_register2};
      ALU_SUB: wide = {1'b0, alu_register1} - {1'b0, alu_register2};
      ALU_AND: wide = {1'b0, alu_register1 & alu_register2};
      ALU_OR:  wide = {1'b0, alu_register1 | alu_register2};
      ALU_XOR: wide = {1'b0, alu_register1 ^ alu_register2};
      default: wide = '0;
    endcase
  end

  assign alu_result   = wide[DATA_BUS_WIDTH-1:0];
  assign alu_is_carry = wide[DATA_BUS_WIDTH];
  assign alu_is_zero  = (wide[DATA_BUS_WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_regfile.sv
// Register file: one synchronous write port, two asynchronous read ports.
module alu_regfile #(
  parameter  int unsigned DATA_BUS_WIDTH = 8,
  parameter  int unsigned NUM_REGS       = 4,
  localparam int unsigned RA_W           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [RA_W-1:0]           waddr_i,
  input  logic [DATA_BUS_WIDTH-1:0] wdata_i,
  input  logic [RA_W-1:0]           raddr1_i,
  input  logic [RA_W-1:0]           raddr2_i,
  output logic [DATA_BUS_WIDTH-1:0] rdata1_o,
  output logic [DATA_BUS_WIDTH-1:0] rdata2_o
);

  logic [DATA_BUS_WIDTH-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: reads two registers, drives an external ALU, writes
// back the result and flags, then holds the response until it is consumed.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter  int unsigned DATA_BUS_WIDTH = 8,
  parameter  int unsigned NUM_REGS       = 4,
  localparam int unsigned RA_W           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_en,
  input  logic [RA_W-1:0]           ld_addr,
  input  logic [DATA_BUS_WIDTH-1:0] ld_data,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  alu_op_e                   req_op,
  input  logic [RA_W-1:0]           req_rs1,
  input  logic [RA_W-1:0]           req_rs2,
  input  logic [RA_W-1:0]           req_rd,
  input  logic                      req_wr_en,
  input  logic                      req_flags_en,
  output alu_op_e                   alu_op,
  output logic [DATA_BUS_WIDTH-1:0] alu_register1,
  output logic [DATA_BUS_WIDTH-1:0] alu_register2,
  input  logic [DATA_BUS_WIDTH-1:0] alu_result,
  input  logic                      alu_is_carry,
  input  logic                      alu_is_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_BUS_WIDTH-1:0] rsp_result,
  output logic                      flag_carry,
  output logic                      flag_zero,
  output logic                      busy
);

  alu_seq_state_e            state_q, state_d;
  alu_op_e                   op_q, op_d;
  logic [RA_W-1:0]           rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                      wr_en_q, wr_en_d, flags_en_q, flags_en_d;
  logic [DATA_BUS_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [DATA_BUS_WIDTH-1:0] res_q, res_d;
  logic                      carry_q, carry_d, zero_q, zero_d;
  logic                      flag_carry_q, flag_carry_d, flag_zero_q, flag_zero_d;

  logic                      rf_we;
  logic [RA_W-1:0]           rf_waddr;
  logic [DATA_BUS_WIDTH-1:0] rf_wdata, rf_rdata1, rf_rdata2;

  alu_regfile #(
    .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
    .NUM_REGS       (NUM_REGS)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (rs1_q),
    .raddr2_i (rs2_q),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= ALU_OP_IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      wr_en_q      <= 1'b0;
      flags_en_q   <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      flag_carry_q <= 1'b0;
      flag_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      wr_en_q      <= wr_en_d;
      flags_en_q   <= flags_en_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      res_q        <= res_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      flag_carry_q <= flag_carry_d;
      flag_zero_q  <= flag_zero_d;
    end
  end

  // ALU bus is decoded separately from the FSM so the result path back into
  // res_d never shares a process with the operand drive.
  always_comb begin
    alu_op        = ALU_OP_IDLE;
    alu_register1 = '0;
    alu_register2 = '0;
    if (state_q == ST_EXECUTE) begin
      alu_op        = op_q;
      alu_register1 = opa_q;
      alu_register2 = opb_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    wr_en_d      = wr_en_q;
    flags_en_d   = flags_en_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    res_d        = res_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    flag_carry_d = flag_carry_q;
    flag_zero_d  = flag_zero_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;

    case (state_q)
      ST_IDLE: begin
        // A load owns the write port this cycle, so requests wait.
        if (ld_en) begin
          rf_we    = 1'b1;
          rf_waddr = ld_addr;
          rf_wdata = ld_data;
        end else if (!rst) begin
          req_ready = 1'b1;
          if (req_valid) begin
            op_d       = req_op;
            rs1_d      = req_rs1;
            rs2_d      = req_rs2;
            rd_d       = req_rd;
            wr_en_d    = req_wr_en;
            flags_en_d = req_flags_en;
            state_d    = ST_OPERAND;
          end
        end
      end
      ST_OPERAND: begin
        opa_d   = rf_rdata1;
        opb_d   = rf_rdata2;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        res_d   = alu_result;
        carry_d = alu_is_carry;
        zero_d  = alu_is_zero;
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        if (wr_en_q) begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = res_q;
        end
        if (flags_en_q) begin
          flag_carry_d = carry_q;
          flag_zero_d  = zero_q;
        end
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_result = res_q;
  assign flag_carry = flag_carry_q;
  assign flag_zero  = flag_zero_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer wired to the alu; operation vectors are
// table-driven, handshake/reset/hazard corners are hand-written sequences.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned NR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_en = 1'b0;
  logic [1:0]    ld_addr = '0;
  logic [W-1:0]  ld_data = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  alu_op_e       req_op = ALU_ADD;
  logic [1:0]    req_rs1 = '0, req_rs2 = '0, req_rd = '0;
  logic          req_wr_en = 1'b0, req_flags_en = 1'b0;
  alu_op_e       alu_op;
  logic [W-1:0]  alu_register1, alu_register2, alu_result;
  logic          alu_is_carry, alu_is_zero;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_result;
  logic          flag_carry, flag_zero, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_BUS_WIDTH(W), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_wr_en(req_wr_en), .req_flags_en(req_flags_en),
    .alu_op(alu_op), .alu_register1(alu_register1), .alu_register2(alu_register2),
    .alu_result(alu_result), .alu_is_carry(alu_is_carry), .alu_is_zero(alu_is_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .flag_carry(flag_carry), .flag_zero(flag_zero), .busy(busy)
  );

  alu #(.DATA_BUS_WIDTH(W)) u_alu (
    .alu_op(alu_op), .alu_register1(alu_register1), .alu_register2(alu_register2),
    .alu_result(alu_result), .alu_is_carry(alu_is_carry), .alu_is_zero(alu_is_zero)
  );

  typedef struct {
    alu_op_e      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [1:0] a, input logic [W-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic issue(input alu_op_e op, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [1:0] d, input logic wr, input logic fl,
                       output logic [W-1:0] res, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_rs1 = s1; req_rs2 = s2; req_rd = d;
    req_wr_en = wr; req_flags_en = fl;
    tick();
    req_valid = 1'b0;
    wait_rsp(lat);
    res = rsp_result;
    if (rsp_valid && rsp_ready) tick();
  endtask

  task automatic readreg(input logic [1:0] r, output logic [W-1:0] v);
    int lat;
    issue(ALU_OR, r, r, 2'd0, 1'b0, 1'b0, v, lat);
  endtask

  initial begin
    logic [W-1:0] res;
    int lat;

    vecs[0]  = '{ALU_ADD, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{ALU_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{ALU_ADD, 8'h7F, 8'h7F, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{ALU_SUB, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    vecs[5]  = '{ALU_SUB, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
    vecs[6]  = '{ALU_SUB, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{ALU_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[8]  = '{ALU_AND, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{ALU_OR,  8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
    vecs[10] = '{ALU_XOR, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{ALU_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_flags", {30'd0, flag_carry, flag_zero}, 32'd0);
    check("idle_alu_op", {29'd0, alu_op}, 32'd0);
    check("idle_alu_regs", {16'd0, alu_register1, alu_register2}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Basic ADD with writeback and flags; RESPOND is the 4th cycle counting
    // from the accepting cycle, i.e. 3 edges after the acceptance edge.
    do_load(2'd0, 8'h0F);
    do_load(2'd1, 8'h01);
    issue(ALU_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, res, lat);
    check("add_result", {24'd0, res}, 32'h10);
    check("add_latency", lat, 32'd3);
    check("add_flags", {30'd0, flag_carry, flag_zero}, 32'd0);
    readreg(2'd2, res);
    check("add_r2", {24'd0, res}, 32'h10);

    // Overflow with flags enabled, then the same with flags disabled
    do_load(2'd0, 8'hFF);
    issue(ALU_ADD, 2'd0, 2'd1, 2'd3, 1'b1, 1'b1, res, lat);
    check("ovf_result", {24'd0, res}, 32'h00);
    check("ovf_flags", {30'd0, flag_carry, flag_zero}, 32'd3);
    do_load(2'd0, 8'h01);
    issue(ALU_ADD, 2'd0, 2'd1, 2'd3, 1'b1, 1'b1, res, lat);
    check("clear_flags", {30'd0, flag_carry, flag_zero}, 32'd0);
    do_load(2'd0, 8'hFF);
    issue(ALU_ADD, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, res, lat);
    check("noflag_result", {24'd0, res}, 32'h00);
    check("noflag_flags_hold", {30'd0, flag_carry, flag_zero}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_load(2'd0, vecs[i].a);
      do_load(2'd1, vecs[i].b);
      issue(vecs[i].op, 2'd0, 2'd1, 2'd3, 1'b1, 1'b1, res, lat);
      check($sformatf("vec%0d_result", i), {24'd0, res}, {24'd0, vecs[i].res});
      check($sformatf("vec%0d_flags", i), {30'd0, flag_carry, flag_zero},
            {30'd0, vecs[i].c, vecs[i].z});
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
      readreg(2'd3, res);
      check($sformatf("vec%0d_rd", i), {24'd0, res}, {24'd0, vecs[i].res});
    end

    // Response back-pressure with a second request waiting
    do_load(2'd0, 8'h33);
    do_load(2'd1, 8'h11);
    rsp_ready = 1'b0;
    issue(ALU_SUB, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, res, lat);
    check("bp_result", {24'd0, res}, 32'h22);
    req_valid = 1'b1; req_op = ALU_ADD; req_rs1 = 2'd0; req_rs2 = 2'd1;
    req_rd = 2'd2; req_wr_en = 1'b0; req_flags_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_hold%0d", i), {22'd0, rsp_valid, req_ready, rsp_result},
            {22'd0, 1'b1, 1'b0, 8'h22});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_idle_after_ready", {30'd0, busy, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp_second_accepted", {31'd0, busy}, 32'd1);
    wait_rsp(lat);
    check("bp_second_result", {24'd0, rsp_result}, 32'h44);
    tick();

    // Load and request together: load wins, request taken one cycle later
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h07;
    req_valid = 1'b1; req_op = ALU_ADD; req_rs1 = 2'd0; req_rs2 = 2'd1;
    req_rd = 2'd3; req_wr_en = 1'b1; req_flags_en = 1'b0;
    #1;
    check("ld_pri_ready", {31'd0, req_ready}, 32'd0);
    tick();
    ld_en = 1'b0;
    #1;
    check("ld_pri_ready_next", {30'd0, busy, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("ld_pri_accepted", {31'd0, busy}, 32'd1);
    wait_rsp(lat);
    check("ld_pri_result", {24'd0, rsp_result}, 32'h18);
    tick();

    // Load strobe during EXECUTE is ignored
    req_valid = 1'b1; req_rd = 2'd3; req_wr_en = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'hEE;
    tick();
    ld_en = 1'b0;
    wait_rsp(lat);
    tick();
    readreg(2'd1, res);
    check("ld_exec_ignored", {24'd0, res}, 32'h11);

    // Reset during WRITEBACK discards the operation
    do_load(2'd0, 8'hFF);
    do_load(2'd1, 8'h02);
    do_load(2'd2, 8'h5A);
    req_valid = 1'b1; req_op = ALU_ADD; req_rs1 = 2'd0; req_rs2 = 2'd1;
    req_rd = 2'd2; req_wr_en = 1'b1; req_flags_en = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("wb_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("wb_rst_state", {30'd0, busy, rsp_valid}, 32'd0);
    check("wb_rst_flags", {30'd0, flag_carry, flag_zero}, 32'd0);
    check("wb_rst_rsp_result", {24'd0, rsp_result}, 32'h00);
    readreg(2'd2, res);
    check("wb_rst_r2", {24'd0, res}, 32'h00);

    // rd == rs1 hazard and back-to-back use of the updated value
    do_load(2'd1, 8'h05);
    issue(ALU_ADD, 2'd1, 2'd1, 2'd1, 1'b1, 1'b0, res, lat);
    check("haz_result", {24'd0, res}, 32'h0A);
    issue(ALU_ADD, 2'd1, 2'd1, 2'd2, 1'b1, 1'b0, res, lat);
    check("haz_b2b_result", {24'd0, res}, 32'h14);
    readreg(2'd1, res);
    check("haz_r1", {24'd0, res}, 32'h0A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
